// File: rtl/float_seq_unit.sv
// Multi-cycle truncating float unit: addf, mulf, f2i, i2f.
// One operation in flight; alignment and normalization run one bit per cycle.
module float_seq_unit #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7,
  parameter int WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  localparam int SW    = MAN_W + 1;                 // significand incl. hidden bit
  localparam int XW    = EXP_W + 2;                 // signed working exponent
  localparam int CNT_W = $clog2(MAN_W + 3);
  localparam logic [EXP_W-1:0]      AMAX_E = EXP_W'(MAN_W + 2);
  localparam logic [CNT_W-1:0]      AMAX_C = CNT_W'(MAN_W + 2);
  localparam logic [CNT_W-1:0]      ONE_C  = CNT_W'(1);
  localparam logic signed [XW-1:0]  ONE_X  = XW'(1);
  localparam logic signed [XW-1:0]  BIAS   = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0]  EMAX   = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0]  I2F_E  = XW'((1 << (EXP_W - 1)) - 1 + WIDTH - 1);
  localparam logic signed [XW-1:0]  MANW_X = XW'(MAN_W);
  localparam logic signed [XW-1:0]  IMAX_X = XW'(WIDTH - 1);
  localparam logic [1:0] OP_ADD = 2'd0, OP_MUL = 2'd1, OP_F2I = 2'd2, OP_I2F = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_EXEC, S_NORM, S_DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [1:0]               r_op;
  logic [WIDTH-1:0]         r_a, r_b, r_m, r_res;
  logic [SW-1:0]            r_ma, r_mb;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [XW-1:0]     r_exp;
  logic                     r_sign;

  // Final packing: overflow saturates to max finite, underflow flushes to signed zero.
  function automatic logic [WIDTH-1:0] pack(input logic s, input logic signed [XW-1:0] e,
                                            input logic [MAN_W-1:0] m);
    if (e >= EMAX)                 pack = {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    else if (e[XW-1] || e == '0)   pack = {s, {(WIDTH-1){1'b0}}};
    else                           pack = {s, e[EXP_W-1:0], m};
  endfunction

  // Alignment distance at accept time, capped where the small operand vanishes.
  logic [EXP_W-1:0] w_ea, w_eb, w_ediff;
  logic [CNT_W-1:0] w_acnt;
  logic             w_go_align;
  assign w_ea       = a[WIDTH-2 -: EXP_W];
  assign w_eb       = b[WIDTH-2 -: EXP_W];
  assign w_ediff    = (w_ea >= w_eb) ? (w_ea - w_eb) : (w_eb - w_ea);
  assign w_acnt     = (w_ediff > AMAX_E) ? AMAX_C : w_ediff[CNT_W-1:0];
  assign w_go_align = (op == OP_ADD) && (w_acnt != '0);

  // Registered operand views used by EXEC.
  logic [EXP_W-1:0]     w_ra_e, w_rb_e;
  logic                 w_sa, w_sb, w_a_big, w_bsign, w_shift_a;
  logic signed [XW-1:0] w_ebig, w_mexp, w_fe;
  logic [SW-1:0]        w_big, w_small, w_dif;
  logic [SW:0]          w_sum;
  logic [2*SW-1:0]      w_prod;
  logic [WIDTH-1:0]     w_sigw, w_fmag, w_imag;
  logic                 w_unused;
  assign w_ra_e    = r_a[WIDTH-2 -: EXP_W];
  assign w_rb_e    = r_b[WIDTH-2 -: EXP_W];
  assign w_sa      = r_a[WIDTH-1];
  assign w_sb      = r_b[WIDTH-1];
  assign w_shift_a = (w_ra_e < w_rb_e);
  assign w_ebig    = w_shift_a ? {2'b00, w_rb_e} : {2'b00, w_ra_e};
  // After alignment the larger-exponent side always has the larger significand.
  assign w_a_big   = (r_ma >= r_mb);
  assign w_big     = w_a_big ? r_ma : r_mb;
  assign w_small   = w_a_big ? r_mb : r_ma;
  assign w_bsign   = w_a_big ? w_sa : w_sb;
  assign w_sum     = {1'b0, w_big} + {1'b0, w_small};
  assign w_dif     = w_big - w_small;
  assign w_prod    = {{SW{1'b0}}, r_ma} * {{SW{1'b0}}, r_mb};
  assign w_mexp    = {2'b00, w_ra_e} + {2'b00, w_rb_e} - BIAS;
  assign w_fe      = {2'b00, w_ra_e} - BIAS;
  assign w_sigw    = {{(WIDTH-SW){1'b0}}, 1'b1, r_a[MAN_W-1:0]};
  assign w_fmag    = (w_fe < MANW_X) ? (w_sigw >> (MANW_X - w_fe)) : (w_sigw << (w_fe - MANW_X));
  assign w_imag    = w_sa ? -r_a : r_a;
  assign w_unused  = ^w_prod[SW-2:0];

  // EXEC: either a finished result or an unnormalized value handed to NORM.
  logic [WIDTH-1:0]     w_x_res, w_x_m;
  logic signed [XW-1:0] w_x_exp;
  logic                 w_x_norm, w_x_sign;
  always_comb begin
    w_x_res  = '0;
    w_x_m    = '0;
    w_x_exp  = '0;
    w_x_norm = 1'b0;
    w_x_sign = 1'b0;
    case (r_op)
      OP_ADD: begin
        if (w_ra_e == '0)      w_x_res = r_b;
        else if (w_rb_e == '0) w_x_res = r_a;
        else if (w_sa == w_sb) begin
          if (w_sum[SW]) w_x_res = pack(w_sa, w_ebig + ONE_X, w_sum[SW-1:1]);
          else           w_x_res = pack(w_sa, w_ebig, w_sum[MAN_W-1:0]);
        end
        else if (w_dif == '0)   w_x_res = '0;
        else if (w_dif[SW-1])   w_x_res = pack(w_bsign, w_ebig, w_dif[MAN_W-1:0]);
        else begin
          w_x_norm = 1'b1;
          w_x_m    = {w_dif, {(WIDTH-SW){1'b0}}};
          w_x_exp  = w_ebig;
          w_x_sign = w_bsign;
        end
      end
      OP_MUL: begin
        if (w_ra_e == '0 || w_rb_e == '0) w_x_res = '0;
        else if (w_prod[2*SW-1]) w_x_res = pack(w_sa ^ w_sb, w_mexp + ONE_X, w_prod[2*SW-2 -: MAN_W]);
        else                     w_x_res = pack(w_sa ^ w_sb, w_mexp, w_prod[2*SW-3 -: MAN_W]);
      end
      OP_F2I: begin
        if (w_ra_e == '0 || w_fe[XW-1]) w_x_res = '0;
        else if (w_fe >= IMAX_X)
          w_x_res = w_sa ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
          w_x_res = w_sa ? -w_fmag : w_fmag;
      end
      default: begin
        if (w_imag == '0)             w_x_res = '0;
        else if (w_imag[WIDTH-1])     w_x_res = pack(w_sa, I2F_E, w_imag[WIDTH-2 -: MAN_W]);
        else begin
          w_x_norm = 1'b1;
          w_x_m    = w_imag;
          w_x_exp  = I2F_E;
          w_x_sign = w_sa;
        end
      end
    endcase
  end

  // NORM step: one left shift per cycle until the hidden bit reaches the top.
  logic [WIDTH-1:0]     w_n_m, w_n_res;
  logic signed [XW-1:0] w_n_exp;
  logic                 w_n_done;
  assign w_n_m    = r_m << 1;
  assign w_n_exp  = r_exp - ONE_X;
  assign w_n_done = w_n_m[WIDTH-1];
  assign w_n_res  = pack(r_sign, w_n_exp, w_n_m[WIDTH-2 -: MAN_W]);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE:  begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_go_align ? S_ALIGN : S_EXEC;
      end
      S_ALIGN: if (r_cnt == ONE_C) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = w_x_norm ? S_NORM : S_DONE;
      S_NORM:  if (w_n_done) w_state_nxt = S_DONE;
      S_DONE:  begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers; result only changes when entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= '0; r_a <= '0; r_b <= '0; r_ma <= '0; r_mb <= '0;
      r_cnt <= '0; r_m <= '0; r_exp <= '0; r_sign <= 1'b0; r_res <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op  <= op;
          r_a   <= a;
          r_b   <= b;
          r_ma  <= {1'b1, a[MAN_W-1:0]};
          r_mb  <= {1'b1, b[MAN_W-1:0]};
          r_cnt <= w_acnt;
        end
        S_ALIGN: begin
          if (w_shift_a) r_ma <= r_ma >> 1;
          else           r_mb <= r_mb >> 1;
          r_cnt <= r_cnt - ONE_C;
        end
        S_EXEC: begin
          if (w_x_norm) begin
            r_m    <= w_x_m;
            r_exp  <= w_x_exp;
            r_sign <= w_x_sign;
          end else begin
            r_res  <= w_x_res;
          end
        end
        S_NORM: begin
          r_m   <= w_n_m;
          r_exp <= w_n_exp;
          if (w_n_done) r_res <= w_n_res;
        end
        default: ;
      endcase
    end
  end

  assign result = r_res;
endmodule

// File: tb/tb_float_seq_unit.sv
// Bench for float_seq_unit: directed vector table, handshake/reset sequences,
// and randomized operations against an integer-arithmetic reference model.
module tb_float_seq_unit;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  op;
  logic [15:0] a, b, result;

  float_seq_unit #(.EXP_W(8), .MAN_W(7)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b, res;
    int          lat;   // -1: latency not checked
  } vec_t;
  vec_t tv [18];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference pack: exponent overflow saturates, underflow flushes to signed zero.
  function automatic logic [15:0] pk(input int s, input int e, input int m);
    logic [15:0] r;
    if (e >= 255)    r = {s[0], 8'hFE, 7'h7F};
    else if (e <= 0) r = {s[0], 15'h0};
    else             r = {s[0], e[7:0], m[6:0]};
    return r;
  endfunction

  // Reference model: values handled as signed integer significands.
  function automatic void model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] res, output int lat);
    int sa, sb, ea, eb, ma, mb, e, d, va, vb, r, s, n, fe, mag, p;
    longint v;
    sa = int'(x[15]); sb = int'(y[15]);
    ea = int'(x[14:7]); eb = int'(y[14:7]);
    ma = 128 + int'(x[6:0]); mb = 128 + int'(y[6:0]);
    res = 16'h0; lat = 1; n = 0;
    case (o)
      2'd0: begin
        if (ea == 0) begin res = y; lat = -1; end
        else if (eb == 0) begin res = x; lat = -1; end
        else begin
          d  = (ea > eb) ? ea - eb : eb - ea;
          e  = (ea > eb) ? ea : eb;
          va = ma >> (e - ea);
          vb = mb >> (e - eb);
          if (sa == 1) va = -va;
          if (sb == 1) vb = -vb;
          r  = va + vb;
          s  = (r < 0) ? 1 : 0;
          if (r < 0) r = -r;
          if (r == 0) res = 16'h0;
          else begin
            while (r >= 256) begin r = r >> 1; e++; end
            while (r < 128)  begin r = r << 1; e--; n++; end
            res = pk(s, e, r);
          end
          lat = 1 + ((d > 9) ? 9 : d) + n;
        end
      end
      2'd1: begin
        if (ea == 0 || eb == 0) res = 16'h0;
        else begin
          p = ma * mb;
          e = ea + eb - 127;
          if (p >= 32768) begin e++; p = p >> 8; end
          else p = p >> 7;
          res = pk(sa ^ sb, e, p);
        end
      end
      2'd2: begin
        fe = ea - 127;
        if (ea == 0 || fe < 0) res = 16'h0;
        else if (fe >= 15) res = (sa == 1) ? 16'h8000 : 16'h7FFF;
        else begin
          v = (longint'(ma) << fe) >> 7;
          res = (sa == 1) ? 16'(-v) : 16'(v);
        end
      end
      default: begin
        mag = (x[15]) ? 65536 - int'(x) : int'(x);
        if (mag == 0) res = 16'h0;
        else begin
          p = 0;
          for (int k = 0; k < 16; k++) if (mag[k]) p = k;
          n = 15 - p;
          res = pk(sa, 127 + p, (mag << n) >> 8);
          lat = 1 + n;
        end
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    int g;
    g = 0;
    while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
    if (!in_ready) chk("issue_ready_timeout", 0, 1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 300);
    if (!out_valid) begin
      n_checks++; n_errors++;
      $display("FAIL done_timeout got out_valid 0 expected 1");
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] r, output int lat);
    issue(o, x, y);
    wait_done(lat);
    r = result;
    consume();
  endtask

  initial begin
    logic [15:0] r, er, x, y;
    logic [1:0]  o;
    int          lat, el;

    tv[0]  = '{op:2'd0, a:16'h3F80, b:16'h4000, res:16'h4040, lat:2};
    tv[1]  = '{op:2'd1, a:16'h3FC0, b:16'h4000, res:16'h4040, lat:1};
    tv[2]  = '{op:2'd1, a:16'h7F00, b:16'h7F00, res:16'h7F7F, lat:1};
    tv[3]  = '{op:2'd3, a:16'h0005, b:16'h0000, res:16'h40A0, lat:14};
    tv[4]  = '{op:2'd3, a:16'h0000, b:16'h0000, res:16'h0000, lat:1};
    tv[5]  = '{op:2'd2, a:16'hC0A0, b:16'h0000, res:16'hFFFB, lat:1};
    tv[6]  = '{op:2'd2, a:16'h3F00, b:16'h0000, res:16'h0000, lat:1};
    tv[7]  = '{op:2'd2, a:16'h4F00, b:16'h0000, res:16'h7FFF, lat:1};
    tv[8]  = '{op:2'd0, a:16'h4040, b:16'hC040, res:16'h0000, lat:1};
    tv[9]  = '{op:2'd3, a:16'h8000, b:16'h0000, res:16'hC700, lat:1};
    tv[10] = '{op:2'd1, a:16'h0000, b:16'h4000, res:16'h0000, lat:1};
    tv[11] = '{op:2'd0, a:16'h0000, b:16'hC040, res:16'hC040, lat:-1};
    tv[12] = '{op:2'd2, a:16'hC700, b:16'h0000, res:16'h8000, lat:1};
    tv[13] = '{op:2'd1, a:16'h8080, b:16'h0080, res:16'h8000, lat:1};
    tv[14] = '{op:2'd0, a:16'h7F7F, b:16'h7F7F, res:16'h7F7F, lat:1};
    tv[15] = '{op:2'd0, a:16'h3F80, b:16'hBF00, res:16'h3F00, lat:3};
    tv[16] = '{op:2'd2, a:16'h4300, b:16'h0000, res:16'h0080, lat:1};
    tv[17] = '{op:2'd3, a:16'hFFFB, b:16'h0000, res:16'hC0A0, lat:14};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    reset = 1'b0;

    foreach (tv[i]) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, r, lat);
      chk($sformatf("vec%0d_res", i), r, tv[i].res);
      if (tv[i].lat >= 0) chk($sformatf("vec%0d_lat", i), lat, tv[i].lat);
    end

    // Result held while the consumer stalls; new offers ignored in DONE.
    issue(2'd0, 16'h4040, 16'hC040);
    wait_done(lat);
    chk("hold_lat", lat, 1);
    in_valid = 1'b1; op = 2'd1; a = 16'h3FC0; b = 16'h4000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", result, 0);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    consume();
    chk("hold_release_in_ready", in_ready, 1);
    chk("hold_release_out_valid", out_valid, 0);

    for (int i = 0; i < 300; i++) begin
      o = 2'($urandom_range(0, 3));
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        x[14:7] = 8'($urandom_range(118, 136));
        y[14:7] = 8'($urandom_range(118, 136));
      end
      model(o, x, y, er, el);
      run_op(o, x, y, r, lat);
      chk($sformatf("rand%0d_op%0d_res", i, o), r, er);
      if (el >= 0) chk($sformatf("rand%0d_op%0d_lat", i, o), lat, el);
    end

    // Reset in the middle of a long alignment, with an offer held across reset.
    run_op(2'd1, 16'h3FC0, 16'h4000, r, lat);
    chk("pre_reset_res", r, 16'h4040);
    issue(2'd0, 16'h4700, 16'h3F80);
    @(posedge clk); #1;
    chk("align_busy_out_valid", out_valid, 0);
    chk("align_busy_in_ready", in_ready, 0);
    reset = 1'b1;
    in_valid = 1'b1; op = 2'd1; a = 16'h3FC0; b = 16'h4000;
    @(posedge clk); #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_result", result, 0);
    @(posedge clk); #1;
    chk("rst_hold_not_accepted", in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_accept", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_out_valid", out_valid, 1);
    chk("post_rst_result", result, 16'h4040);
    consume();
    chk("post_rst_idle", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/float_seq_unit.md
FLOAT_SEQ_UNIT -- requirements
Module: float_seq_unit

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 7, meaning stored mantissa width, excluding the hidden 1.
REQ-003 SHALL have derived parameter WIDTH = 1+EXP_W+MAN_W, default 16, meaning the float and integer word width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the unit can accept an operation.
REQ-008 SHALL have port op, input, 2 bits: 00 addf, 01 mulf, 10 f2i, 11 i2f.
REQ-009 SHALL have ports a and b, input, WIDTH bits each: the operands; b is used only by addf and mulf.
REQ-010 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port result, output, WIDTH bits: the operation result.

Function
REQ-013 SHALL use float format {sign, exponent, mantissa} with bias 2^(EXP_W-1)-1 and a hidden leading 1; exponent 0 is zero; no denormals, Inf or NaN; all results truncate (round toward zero).
REQ-014 SHALL use FSM states IDLE, ALIGN, EXEC, NORM, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); one operation in flight at a time.
REQ-015 SHALL accept an operation on an edge with in_valid && in_ready, registering op, a and b; the next state is ALIGN if A>0, else EXEC.
REQ-016 SHALL, for addf, define A = min(|ea-eb|, MAN_W+2); ALIGN right-shifts the smaller-exponent significand one bit per cycle for A cycles; a larger difference leaves that operand's contribution as 0.
REQ-017 SHALL complete EXEC in one cycle: addf adds or subtracts significands by sign; on carry-out, shifts right 1 and increments the exponent. mulf multiplies significands to 2*(MAN_W+1) bits, uses exponent ea+eb-bias, and on a top-bit product increments the exponent.
REQ-018 SHALL use NORM for addf cancellation and i2f: left-shift one bit per cycle until the hidden bit is set, decrementing the exponent each cycle; N = number of NORM cycles.
REQ-019 SHALL have out_valid rise exactly 1+A+N edges after the accepting edge; mulf and f2i have A=N=0.
REQ-020 SHALL, for i2f, treat a as two's complement, take the magnitude in EXEC with exponent bias+WIDTH-1, then normalize in NORM; a=0 gives result 0 with N=0; -2^(WIDTH-1) is handled exactly.
REQ-021 SHALL, for f2i, truncate toward zero and saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; an unbiased exponent below 0 gives 0.
REQ-022 SHALL return any zero operand to addf as the other operand, return 0 from mulf if either operand is zero, and return +0 (all bits 0) on exact cancellation.
REQ-023 SHALL saturate exponent overflow to the signed max finite value (exponent all-ones minus 1, mantissa all-ones) and flush exponent underflow (<=0) to signed zero.
REQ-024 SHALL hold result and out_valid stable in DONE until out_ready; on an edge with out_ready the state goes to IDLE; in_valid is ignored outside IDLE.

Reset
REQ-025 SHALL, on reset high at an edge, set state=IDLE, out_valid=0, in_ready=1 and result=0, discarding any in-flight operation regardless of state.
REQ-026 SHALL let reset take priority over every handshake; an in_valid held during reset is not accepted until the first edge with reset low.

Verification (WIDTH=16, EXP_W=8, MAN_W=7)
REQ-027 SHALL cover: addf a=0x3F80, b=0x4000 -> result 0x4040, out_valid 2 edges after accept (A=1).
REQ-028 SHALL cover: mulf a=0x3FC0, b=0x4000 -> 0x4040 after 1 edge; mulf 0x7F00*0x7F00 -> 0x7F7F (saturate).
REQ-029 SHALL cover: i2f a=0x0005 -> 0x40A0 after 14 edges (N=13); i2f 0x0000 -> 0x0000 after 1 edge.
REQ-030 SHALL cover: f2i a=0xC0A0 -> 0xFFFB; f2i 0x3F00 -> 0x0000; f2i 0x4F00 -> 0x7FFF.
REQ-031 SHALL cover: addf 0x4040 + 0xC040 -> 0x0000; out_ready held low 5 cycles -> result and out_valid stable throughout, in_ready=0.
REQ-032 SHALL cover: reset asserted during ALIGN of addf 0x4700+0x3F80 -> next edge out_valid=0, in_ready=1, result=0; a following mulf completes normally.
